spike_rate_decoder: RTL and testbench

Rate decoder at the output end of the spiking neural network. It is the counterpart of the input spike encoder. It counts spikes on each output-neuron channel over a fixed window of clock cycles, then publishes the per-channel counts and a one-cycle `valid` pulse. It optionally also publishes a winner-take-all class index. It sits between `SpikingNeuralNetwork.output_spikes` and the chip output pins, replacing direct raw-spike mapping.

---
 rtl/snn_pkg.sv | 33 +++
 rtl/spike_argmax.sv | 39 +++
 rtl/spike_rate_decoder.sv | 145 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// +--------------------------------------------------------------------------+
// | snn_pkg : shared types, defaults and width helper for the SNN datapath    |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package snn_pkg;

  localparam int unsigned SNN_N_OUT   = 2;
  localparam int unsigned SNN_WIN_LEN = 16;

  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_COUNT = 2'd1,
    SD_DONE  = 2'd2
  } spike_dec_state_t;

  // Ceiling log2; returns 0 for values of 0 or 1, callers clamp to 1 bit.
  function automatic int unsigned snn_clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_argmax.sv
// +--------------------------------------------------------------------------+
// | spike_argmax : combinational argmax over packed counts, lowest index wins |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module spike_argmax
  import snn_pkg::*;
#(
  parameter int unsigned N_CH  = SNN_N_OUT,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIDX  = 1
) (
  input  logic [N_CH*CNT_W-1:0] counts,
  output logic [WIDX-1:0]       winner,
  output logic                  tie
);

  logic [CNT_W-1:0] max_val;

  // Strict '>' keeps the earliest channel on equality; equality only flags a tie.
  always_comb begin
    max_val = counts[0 +: CNT_W];
    winner  = '0;
    tie     = 1'b0;
    for (int i = 1; i < N_CH; i++) begin
      if (counts[i*CNT_W +: CNT_W] > max_val) begin
        max_val = counts[i*CNT_W +: CNT_W];
        winner  = WIDX'(i);
        tie     = 1'b0;
      end else if (counts[i*CNT_W +: CNT_W] == max_val) begin
        tie = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// +--------------------------------------------------------------------------+
// | spike_rate_decoder : windowed per-channel spike counter with optional WTA |
// | Build option : define SPIKE_DEC_WTA_EN to compile in winner/tie logic     |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter  int unsigned N_CH    = SNN_N_OUT,
  parameter  int unsigned WIN_LEN = SNN_WIN_LEN,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned WIDX    = (snn_clog2(N_CH) > 1) ? snn_clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       spikes,
  output logic                  valid,
  output logic [N_CH*CNT_W-1:0] counts,
  output logic [WIDX-1:0]       winner,
  output logic                  tie
);

  localparam int unsigned      WIN_W    = (snn_clog2(WIN_LEN) > 1) ? snn_clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  spike_dec_state_t      state_q, state_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [CNT_W-1:0]      cnt_q [N_CH];
  logic [CNT_W-1:0]      cnt_d [N_CH];
  logic [N_CH*CNT_W-1:0] cnt_packed;

  logic                  valid_q, valid_d;
  logic [N_CH*CNT_W-1:0] counts_q, counts_d;
  logic [WIDX-1:0]       winner_q, winner_d;
  logic                  tie_q, tie_d;

  logic [WIDX-1:0]       wta_winner;
  logic                  wta_tie;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign cnt_packed[g*CNT_W +: CNT_W] = cnt_q[g];
    end
  endgenerate

`ifdef SPIKE_DEC_WTA_EN
  spike_argmax #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .WIDX  (WIDX)
  ) u_argmax (
    .counts (cnt_packed),
    .winner (wta_winner),
    .tie    (wta_tie)
  );
`else
  assign wta_winner = '0;
  assign wta_tie    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    counts_d = counts_q;
    winner_d = winner_q;
    tie_d    = tie_q;

    case (state_q)
      SD_IDLE: begin
        win_d = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
        if (enable) state_d = SD_COUNT;
      end

      SD_COUNT: begin
        if (!enable) begin
          // Abort: the partial window is dropped and published results stay put.
          state_d = SD_IDLE;
          win_d   = '0;
          for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            if (spikes[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          if (win_q == WIN_LAST) begin
            state_d = SD_DONE;
            win_d   = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
      end

      SD_DONE: begin
        valid_d  = 1'b1;
        counts_d = cnt_packed;
        winner_d = wta_winner;
        tie_d    = wta_tie;
        win_d    = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
        state_d  = enable ? SD_COUNT : SD_IDLE;
      end

      default: begin
        state_d = SD_IDLE;
        win_d   = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SD_IDLE;
      win_q    <= '0;
      cnt_q    <= '{default: '0};
      valid_q  <= 1'b0;
      counts_q <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      counts_q <= counts_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  assign valid  = valid_q;
  assign counts = counts_q;
  assign winner = winner_q;
  assign tie    = tie_q;

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_spike_rate_decoder : directed self-checking bench for the decoder      |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spike_rate_decoder;

`ifdef SPIKE_DEC_WTA_EN
  localparam bit WTA = 1'b1;
`else
  localparam bit WTA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  spikes;

  logic        valid;
  logic [15:0] counts;
  logic [0:0]  winner;
  logic        tie;

  logic        s_valid;
  logic [5:0]  s_counts;
  logic [0:0]  s_winner;
  logic        s_tie;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(
    .N_CH    (2),
    .WIN_LEN (16),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .spikes (spikes),
    .valid  (valid),
    .counts (counts),
    .winner (winner),
    .tie    (tie)
  );

  // Narrow counters share the stimulus so saturation can be observed.
  spike_rate_decoder #(
    .N_CH    (2),
    .WIN_LEN (16),
    .CNT_W   (3)
  ) dut_sat (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .spikes (spikes),
    .valid  (s_valid),
    .counts (s_counts),
    .winner (s_winner),
    .tie    (s_tie)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs read there reflect the last rising edge.
  task automatic drive(input logic en, input logic [1:0] spk);
    @(negedge clk);
    enable = en;
    spikes = spk;
  endtask

  task automatic check_result(input string tag, input int n0, input int n1,
                              input int w, input int t);
    chk({tag, "_valid"},  32'(valid),  32'd1);
    chk({tag, "_counts"}, 32'(counts), (32'(n1) << 8) | 32'(n0));
    chk({tag, "_winner"}, 32'(winner), WTA ? 32'(w) : 32'd0);
    chk({tag, "_tie"},    32'(tie),    WTA ? 32'(t) : 32'd0);
  endtask

  // One window from IDLE: ch0 spikes in the first n0 samples, ch1 in the first n1,
  // done_spk is driven during DONE with enable low. Ends at the valid cycle.
  task automatic run_win(input int n0, input int n1, input logic [1:0] done_spk);
    logic b0, b1;
    drive(1'b1, 2'b00);
    for (int k = 0; k < 16; k++) begin
      b0 = (k < n0);
      b1 = (k < n1);
      drive(1'b1, {b1, b0});
      chk("win_no_valid", 32'(valid), 32'd0);
    end
    drive(1'b0, done_spk);
    chk("done_no_valid", 32'(valid), 32'd0);
    drive(1'b0, 2'b00);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    spikes = 2'b00;

    // Reset held with enable high and random spikes
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      spikes = 2'($urandom);
      chk("rst_valid",  32'(valid),    32'd0);
      chk("rst_counts", 32'(counts),   32'd0);
      chk("rst_winner", 32'(winner),   32'd0);
      chk("rst_tie",    32'(tie),      32'd0);
      chk("rst_scount", 32'(s_counts), 32'd0);
    end
    reset = 1'b0;
    drive(1'b1, 2'($urandom));
    chk("post_rst_valid",  32'(valid),  32'd0);
    chk("post_rst_counts", 32'(counts), 32'd0);
    chk("post_rst_winner", 32'(winner), 32'd0);
    chk("post_rst_tie",    32'(tie),    32'd0);
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);

    // Continuous enable, ch0 every cycle: pulses at E+18 and E+35 only
    drive(1'b1, 2'b01);
    for (int c = 1; c <= 35; c++) begin
      drive(1'b1, 2'b01);
      chk("cont_valid", 32'(valid), (c == 18 || c == 35) ? 32'd1 : 32'd0);
      if (c == 18 || c == 35) check_result("cont", 16, 0, 0, 0);
    end
    drive(1'b0, 2'b00);
    chk("cont_end_valid", 32'(valid), 32'd0);
    drive(1'b0, 2'b00);

    // ch1 wins; a ch0 spike in DONE must be lost
    run_win(5, 10, 2'b01);
    check_result("ch1_wins", 5, 10, 1, 0);
    chk("ch1_wins_sat", 32'(s_counts), 32'h3D);
    drive(1'b0, 2'b00);
    chk("ch1_wins_pulse_end", 32'(valid), 32'd0);
    chk("ch1_wins_hold", 32'(counts), 32'h0A05);

    // Equal counts and the all-zero window both tie
    run_win(7, 7, 2'b00);
    check_result("tie7", 7, 7, 0, 1);
    run_win(0, 0, 2'b00);
    check_result("tie0", 0, 0, 0, 1);

    // Full-window spikes saturate the 3-bit counters at 7
    run_win(16, 16, 2'b00);
    check_result("full16", 16, 16, 0, 1);
    chk("sat_valid",  32'(s_valid),  32'd1);
    chk("sat_counts", 32'(s_counts), 32'h3F);

    // Known result, then an aborted window must not disturb it
    run_win(3, 1, 2'b00);
    check_result("pre_abort", 3, 1, 0, 0);
    drive(1'b1, 2'b00);
    for (int k = 0; k < 8; k++) drive(1'b1, 2'b10);
    drive(1'b0, 2'b10);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 2'b00);
      chk("abort_no_valid", 32'(valid), 32'd0);
    end
    chk("abort_hold_counts", 32'(counts), 32'h0103);
    chk("abort_hold_winner", 32'(winner), 32'd0);
    chk("abort_hold_tie",    32'(tie),    32'd0);

    // Reset in the middle of a later window
    drive(1'b1, 2'b00);
    for (int k = 0; k < 8; k++) drive(1'b1, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b11);
    chk("midrst_valid",  32'(valid),    32'd0);
    chk("midrst_counts", 32'(counts),   32'd0);
    chk("midrst_winner", 32'(winner),   32'd0);
    chk("midrst_tie",    32'(tie),      32'd0);
    chk("midrst_scount", 32'(s_counts), 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 2'b11);
      chk("midrst_no_valid", 32'(valid), 32'd0);
    end

    // Normal operation resumes after reset
    run_win(2, 4, 2'b00);
    check_result("resume", 2, 4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
